// File: rtl/ascon_decrypt_iter.sv
// ascon_decrypt_iter
//
// Iterative single-block Ascon-128 decryptor. It is the inverse of the
// single-block combinational encryptor: a 320-bit state x0..x4 is advanced
// one permutation round per clock. The schedule is:
//   INIT p12, key XOR, AD XOR, AD p6, domain bit, text swap, TXT p6,
//   key XOR, FIN p12, tag compare.
// The handshake edge is followed by 36 round edges. The last round edge
// also raises out_valid.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. The producer holds its data stable while valid is 1 and ready is 0.
// in_ready is 1 only in IDLE. out_valid is 1 only in DONE, and P/tag_ok do
// not change while out_valid is 1 and out_ready is 0.
//
// Optional build macro: ASCON_DEC_PT_GATE_EN. When it is defined, P reads
// zero whenever tag_ok is 0.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   SK, N, A, C, T      key, nonce, AD block, ciphertext block and received
//                       tag; all are sampled on the input handshake
//   in_valid, in_ready  input handshake
//   P, tag_ok           recovered plaintext and tag-match flag
//   out_valid, out_ready output handshake
//   dbg_state           current FSM state (IDLE=0 INIT=1 AD=2 TXT=3 FIN=4 DONE=5)
module ascon_decrypt_iter #(
  parameter logic [63:0] IV = 64'h80400c0600000000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] SK,
  input  logic [127:0] N,
  input  logic [63:0]  A,
  input  logic [63:0]  C,
  input  logic [127:0] T,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [63:0]  P,
  output logic         tag_ok,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [2:0]   dbg_state
);

  typedef logic [4:0][63:0] ascon_state_t;  // element i is xi

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_AD   = 3'd2,
    S_TXT  = 3'd3,
    S_FIN  = 3'd4,
    S_DONE = 3'd5
  } state_e;

  state_e       state, state_nxt;
  logic [3:0]   rnd, rnd_nxt;
  logic [3:0]   rnd_inv;
  logic [7:0]   rc;
  logic         last_rnd;
  logic         in_fire;
  ascon_state_t x, x_nxt, x_rnd;
  logic [127:0] sk_q, t_q;
  logic [63:0]  a_q, c_q;
  logic [63:0]  p_q, p_nxt;
  logic         tag_q, tag_nxt;

  function automatic logic [63:0] ror(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // One Ascon round: constant add, 5-bit S-box layer, linear diffusion.
  function automatic ascon_state_t ascon_round(input ascon_state_t s, input logic [7:0] c);
    ascon_state_t u;
    logic [63:0]  t0, t1, t2, t3, t4;
    u    = s;
    u[2] = u[2] ^ {56'h0, c};
    u[0] = u[0] ^ u[4];
    u[4] = u[4] ^ u[3];
    u[2] = u[2] ^ u[1];
    t0   = ~u[0] & u[1];
    t1   = ~u[1] & u[2];
    t2   = ~u[2] & u[3];
    t3   = ~u[3] & u[4];
    t4   = ~u[4] & u[0];
    u[0] = u[0] ^ t1;
    u[1] = u[1] ^ t2;
    u[2] = u[2] ^ t3;
    u[3] = u[3] ^ t4;
    u[4] = u[4] ^ t0;
    u[1] = u[1] ^ u[0];
    u[0] = u[0] ^ u[4];
    u[3] = u[3] ^ u[2];
    u[2] = ~u[2];
    u[0] = u[0] ^ ror(u[0], 19) ^ ror(u[0], 28);
    u[1] = u[1] ^ ror(u[1], 61) ^ ror(u[1], 39);
    u[2] = u[2] ^ ror(u[2], 1)  ^ ror(u[2], 6);
    u[3] = u[3] ^ ror(u[3], 10) ^ ror(u[3], 17);
    u[4] = u[4] ^ ror(u[4], 7)  ^ ror(u[4], 41);
    return u;
  endfunction

  assign in_fire  = in_valid & (state == S_IDLE);
  assign rnd_inv  = 4'hF - rnd;
  assign rc       = {rnd_inv, rnd};
  assign last_rnd = (rnd == 4'd11);
  assign x_rnd    = ascon_round(x, rc);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. Every round phase ends when the counter reaches 11.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid)  state_nxt = S_INIT;
      S_INIT:  if (last_rnd)  state_nxt = S_AD;
      S_AD:    if (last_rnd)  state_nxt = S_TXT;
      S_TXT:   if (last_rnd)  state_nxt = S_FIN;
      S_FIN:   if (last_rnd)  state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
    tag_ok    = tag_q;
    dbg_state = state;
`ifdef ASCON_DEC_PT_GATE_EN
    P = tag_q ? p_q : 64'h0;
`else
    P = p_q;
`endif
  end

  // Datapath next values. Each phase-boundary XOR is applied to the output
  // of that phase's final round, on the same edge. p6 phases start the round
  // counter at 6, so the constants follow the tail of the p12 sequence.
  always_comb begin
    x_nxt   = x;
    rnd_nxt = rnd;
    p_nxt   = p_q;
    tag_nxt = tag_q;
    case (state)
      S_IDLE: begin
        if (in_fire) begin
          x_nxt[0] = IV;
          x_nxt[1] = SK[127:64];
          x_nxt[2] = SK[63:0];
          x_nxt[3] = N[127:64];
          x_nxt[4] = N[63:0];
          rnd_nxt  = 4'd0;
        end
      end
      S_INIT: begin
        x_nxt   = x_rnd;
        rnd_nxt = rnd + 4'd1;
        if (last_rnd) begin
          x_nxt[3] = x_rnd[3] ^ sk_q[127:64];
          x_nxt[4] = x_rnd[4] ^ sk_q[63:0];
          x_nxt[0] = x_rnd[0] ^ a_q;
          rnd_nxt  = 4'd6;
        end
      end
      S_AD: begin
        x_nxt   = x_rnd;
        rnd_nxt = rnd + 4'd1;
        if (last_rnd) begin
          x_nxt[4] = x_rnd[4] ^ 64'h1;
          p_nxt    = x_rnd[0] ^ c_q;
          x_nxt[0] = c_q;
          rnd_nxt  = 4'd6;
        end
      end
      S_TXT: begin
        x_nxt   = x_rnd;
        rnd_nxt = rnd + 4'd1;
        if (last_rnd) begin
          x_nxt[1] = x_rnd[1] ^ sk_q[127:64];
          x_nxt[2] = x_rnd[2] ^ sk_q[63:0];
          rnd_nxt  = 4'd0;
        end
      end
      S_FIN: begin
        x_nxt   = x_rnd;
        rnd_nxt = rnd + 4'd1;
        if (last_rnd) begin
          tag_nxt = (({x_rnd[3], x_rnd[4]} ^ sk_q) == t_q);
          rnd_nxt = 4'd0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x     <= '0;
      rnd   <= 4'd0;
      p_q   <= 64'h0;
      tag_q <= 1'b0;
      sk_q  <= 128'h0;
      t_q   <= 128'h0;
      a_q   <= 64'h0;
      c_q   <= 64'h0;
    end else begin
      x     <= x_nxt;
      rnd   <= rnd_nxt;
      p_q   <= p_nxt;
      tag_q <= tag_nxt;
      if (in_fire) begin
        sk_q <= SK;
        t_q  <= T;
        a_q  <= A;
        c_q  <= C;
      end
    end
  end

endmodule

// File: tb/tb_ascon_decrypt_iter.sv
// tb_ascon_decrypt_iter
//
// Directed and random vectors for ascon_decrypt_iter. A reference Ascon-128
// single-block encryptor produces C and T from a known plaintext. The
// decryptor must then recover that plaintext and report tag_ok=1, or report
// tag_ok=0 when the tag is corrupted.
module tb_ascon_decrypt_iter;

  localparam logic [63:0] IV_W = 64'h80400c0600000000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] SK, N, T;
  logic [63:0]  A, C;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  P;
  logic         tag_ok;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  ascon_decrypt_iter dut (
    .clk(clk), .rst_n(rst_n), .SK(SK), .N(N), .A(A), .C(C), .T(T),
    .in_valid(in_valid), .in_ready(in_ready), .P(P), .tag_ok(tag_ok),
    .out_valid(out_valid), .out_ready(out_ready), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference encryptor ----------------
  function automatic logic [4:0] sbox5(input logic [4:0] v);
    case (v)
      5'd0:  return 5'h04;  5'd1:  return 5'h0b;  5'd2:  return 5'h1f;  5'd3:  return 5'h14;
      5'd4:  return 5'h1a;  5'd5:  return 5'h15;  5'd6:  return 5'h09;  5'd7:  return 5'h02;
      5'd8:  return 5'h1b;  5'd9:  return 5'h05;  5'd10: return 5'h08;  5'd11: return 5'h12;
      5'd12: return 5'h1d;  5'd13: return 5'h03;  5'd14: return 5'h06;  5'd15: return 5'h1c;
      5'd16: return 5'h1e;  5'd17: return 5'h13;  5'd18: return 5'h07;  5'd19: return 5'h0e;
      5'd20: return 5'h00;  5'd21: return 5'h0d;  5'd22: return 5'h11;  5'd23: return 5'h18;
      5'd24: return 5'h10;  5'd25: return 5'h0c;  5'd26: return 5'h01;  5'd27: return 5'h19;
      5'd28: return 5'h16;  5'd29: return 5'h0a;  5'd30: return 5'h0f;  default: return 5'h17;
    endcase
  endfunction

  function automatic logic [63:0] rr(input logic [63:0] v, input int n);
    logic [127:0] d;
    d = {v, v} >> n;
    return d[63:0];
  endfunction

  function automatic int rot_a(input int i);
    case (i) 0: return 19; 1: return 61; 2: return 1; 3: return 10; default: return 7; endcase
  endfunction

  function automatic int rot_b(input int i);
    case (i) 0: return 28; 1: return 39; 2: return 6; 3: return 17; default: return 41; endcase
  endfunction

  // State packed as s[64*i +: 64] = xi.
  function automatic logic [319:0] ref_round(input logic [319:0] s, input int r);
    logic [63:0] w[5];
    logic [4:0]  v, o;
    logic [7:0]  c;
    for (int i = 0; i < 5; i++) w[i] = s[64*i +: 64];
    c = 8'((15 - r) * 16 + r);
    w[2][7:0] = w[2][7:0] ^ c;
    for (int j = 0; j < 64; j++) begin
      v = {w[0][j], w[1][j], w[2][j], w[3][j], w[4][j]};
      o = sbox5(v);
      w[0][j] = o[4]; w[1][j] = o[3]; w[2][j] = o[2]; w[3][j] = o[1]; w[4][j] = o[0];
    end
    for (int i = 0; i < 5; i++) w[i] = w[i] ^ rr(w[i], rot_a(i)) ^ rr(w[i], rot_b(i));
    return {w[4], w[3], w[2], w[1], w[0]};
  endfunction

  function automatic logic [319:0] ref_perm(input logic [319:0] s, input int first);
    logic [319:0] u;
    u = s;
    for (int r = first; r < 12; r++) u = ref_round(u, r);
    return u;
  endfunction

  task automatic ref_encrypt(input logic [127:0] sk, n, input logic [63:0] a, p,
                             output logic [63:0] c, output logic [127:0] t);
    logic [319:0] s;
    s = {n[63:0], n[127:64], sk[63:0], sk[127:64], IV_W};
    s = ref_perm(s, 0);
    s[192 +: 64] = s[192 +: 64] ^ sk[127:64];
    s[256 +: 64] = s[256 +: 64] ^ sk[63:0];
    s[63:0]      = s[63:0] ^ a;
    s = ref_perm(s, 6);
    s[256]   = s[256] ^ 1'b1;
    s[63:0]  = s[63:0] ^ p;
    c        = s[63:0];
    s = ref_perm(s, 6);
    s[64 +: 64]  = s[64 +: 64] ^ sk[127:64];
    s[128 +: 64] = s[128 +: 64] ^ sk[63:0];
    s = ref_perm(s, 0);
    t = {s[192 +: 64], s[256 +: 64]} ^ sk;
  endtask

  // ---------------- driver tasks ----------------
  // Returns #1 after the handshake edge.
  task automatic send_req(input logic [127:0] sk, n, input logic [63:0] a, c,
                          input logic [127:0] t, input logic [63:0] exp_p);
    int w;
    w = 0;
    SK = sk; N = n; A = a; C = c; T = t;
    in_valid = 1'b1;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    check("accept_wait", {127'h0, (w < 50)}, 128'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back(exp_p);
  endtask

  task automatic wait_out(input int start, output int lat);
    lat = start;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic check_result(input string tag, input int lat, input logic exp_tag);
    logic [63:0] e;
    check({tag, "_latency"}, 128'(lat), 128'd36);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'h0;
    check({tag, "_P"}, {64'h0, P}, {64'h0, e});
    check({tag, "_tag_ok"}, {127'h0, tag_ok}, {127'h0, exp_tag});
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_out_valid", {127'h0, out_valid}, 128'h0);
    check("release_in_ready", {127'h0, in_ready}, 128'h1);
  endtask

  function automatic logic [63:0] gated_p(input logic [63:0] p, input logic good);
`ifdef ASCON_DEC_PT_GATE_EN
    return good ? p : 64'h0;
`else
    return p;
`endif
  endfunction

  task automatic run_txn(input string tag, input logic [127:0] sk, n,
                         input logic [63:0] a, p, input logic flip);
    logic [63:0]  c;
    logic [127:0] t;
    int           lat;
    ref_encrypt(sk, n, a, p, c, t);
    if (flip) t[0] = ~t[0];
    send_req(sk, n, a, c, t, gated_p(p, !flip));
    wait_out(0, lat);
    check_result(tag, lat, !flip);
    release_out();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] rsk, rn, tt;
    logic [63:0]  ra, rp, cc;
    int           lat;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    SK = '0; N = '0; A = '0; C = '0; T = '0;
    #12;
    check("rst_in_ready", {127'h0, in_ready}, 128'h1);
    check("rst_out_valid", {127'h0, out_valid}, 128'h0);
    check("rst_P", {64'h0, P}, 128'h0);
    check("rst_tag_ok", {127'h0, tag_ok}, 128'h0);
    check("rst_state", {125'h0, dbg_state}, 128'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // All-zero vector
    run_txn("zero", 128'h0, 128'h0, 64'h0, 64'h0, 1'b0);

    // Directed patterns
    run_txn("dir1", 128'h000102030405060708090a0b0c0d0e0f, 128'h101112131415161718191a1b1c1d1e1f,
            64'h0123456789abcdef, 64'hfedcba9876543210, 1'b0);
    run_txn("dir2", {128{1'b1}}, 128'h0, 64'hffffffffffffffff, 64'hffffffffffffffff, 1'b0);
    run_txn("dir3", 128'h8000000000000000_0000000000000001, 128'hdeadbeefcafebabe_0123456789abcdef,
            64'h0, 64'h5a5a5a5aa5a5a5a5, 1'b0);

    // Corrupted tag
    run_txn("flip", 128'h000102030405060708090a0b0c0d0e0f, 128'h101112131415161718191a1b1c1d1e1f,
            64'h0123456789abcdef, 64'hfedcba9876543210, 1'b1);

    // Busy-time in_valid with changed inputs, then hold in DONE for 10 cycles
    rp  = 64'h1122334455667788;
    rsk = 128'h0f0e0d0c0b0a09080706050403020100;
    rn  = 128'h55aa55aa55aa55aa33cc33cc33cc33cc;
    ra  = 64'h8877665544332211;
    ref_encrypt(rsk, rn, ra, rp, cc, tt);
    send_req(rsk, rn, ra, cc, tt, rp);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      SK = ~SK; N = ~N; A = ~A; C = ~C; T = ~T;
      check("busy_in_ready", {127'h0, in_ready}, 128'h0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_out(5, lat);
    check_result("busy", lat, 1'b1);
    for (int k = 0; k < 10; k++) begin
      in_valid = k[0];
      check("hold_out_valid", {127'h0, out_valid}, 128'h1);
      check("hold_P", {64'h0, P}, {64'h0, rp});
      check("hold_tag_ok", {127'h0, tag_ok}, 128'h1);
      check("hold_in_ready", {127'h0, in_ready}, 128'h0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    release_out();

    // Reset during FIN round 5: 29 edges after accept are 12+6+6+5
    rp = 64'h0badc0ffee0ddf00;
    ref_encrypt(rsk, rn, ra, rp, cc, tt);
    send_req(rsk, rn, ra, cc, tt, rp);
    repeat (29) begin @(posedge clk); #1; end
    check("pre_rst_state_fin", {125'h0, dbg_state}, 128'h4);
    rst_n = 1'b0;
    #1;
    void'(exp_q.pop_back());
    check("mid_rst_out_valid", {127'h0, out_valid}, 128'h0);
    check("mid_rst_in_ready", {127'h0, in_ready}, 128'h1);
    check("mid_rst_P", {64'h0, P}, 128'h0);
    check("mid_rst_state", {125'h0, dbg_state}, 128'h0);
    #1;
    rst_n = 1'b1;
    run_txn("after_rst", rsk, rn, ra, rp, 1'b0);

    // Random vectors
    for (int v = 0; v < 1000; v++) begin
      rsk = {$urandom, $urandom, $urandom, $urandom};
      rn  = {$urandom, $urandom, $urandom, $urandom};
      ra  = {$urandom, $urandom};
      rp  = {$urandom, $urandom};
      run_txn("rand", rsk, rn, ra, rp, 1'b0);
    end

    check("scoreboard_empty", 128'(exp_q.size()), 128'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ascon_decrypt_iter.md
ASCON_DECRYPT_ITER -- requirements
Module: ascon_decrypt_iter

Interface
REQ-001 SHALL have parameter IV, default 64'h80400c0600000000, the Ascon-128 initialisation word loaded into x0.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SK  input  128  secret key, sampled at input handshake.
REQ-005 N  input  128  nonce, sampled at input handshake.
REQ-006 A  input  64  single associated-data block, sampled at input handshake.
REQ-007 C  input  64  single ciphertext block, sampled at input handshake.
REQ-008 T  input  128  received tag, sampled at input handshake.
REQ-009 in_valid  input  1  request valid; in_ready  output  1  block able to accept.
REQ-010 P  output  64  recovered plaintext block.
REQ-011 tag_ok  output  1  1 when the computed tag equals T.
REQ-012 out_valid  output  1  P/tag_ok valid; out_ready  input  1  consumer accepts.

Function
REQ-013 SHALL be the exact inverse of the team's single-block combinational Ascon-128 encryptor: same IV, same key/nonce layout, same one-AD-block and one-text-block schedule, same domain-separation and finalisation key XORs.
REQ-014 SHALL hold a registered 320-bit state x0..x4 and compute exactly one permutation round (constant add to x2, S-box layer, linear diffusion with rotations 19/28, 61/39, 1/6, 10/17, 7/41) per cycle.
REQ-015 Round constant SHALL be {(4'hF-r),r} for round index r; p12 uses r=0..11 (0xF0..0x4B), p6 uses r=6..11 (0x96..0x4B).
REQ-016 FSM states: IDLE, INIT(12 rounds), AD(6), TXT(6), FIN(12), DONE; a 4-bit round counter sequences rounds and resets to the phase start index on each transition.
REQ-017 in_ready SHALL equal (state==IDLE); input handshake = in_valid & in_ready; on it the state loads {IV,SK,N} and moves to INIT.
REQ-018 INIT->AD: after round 11, {x3,x4} ^= SK, then x0 ^= A, in the same edge.
REQ-019 AD->TXT: after the 6th round, x4 ^= 1 (LSB), then P register captures x0 ^ C and x0 is replaced by C, in the same edge.
REQ-020 TXT->FIN: after the 6th round, {x1,x2} ^= SK.
REQ-021 FIN->DONE: after round 11, tag_ok captures ({x3,x4} ^ SK) == T; out_valid rises.
REQ-022 Latency SHALL be exactly 36 cycles from the input handshake edge to the edge asserting out_valid.
REQ-023 In DONE, P, tag_ok, out_valid SHALL hold stable while out_ready is 0; out_valid & out_ready moves to IDLE with out_valid cleared.
REQ-024 in_valid while not IDLE SHALL be ignored; no input register changes mid-operation.
REQ-025 Next request accepted no earlier than one cycle after the output handshake (throughput one block per 38 cycles minimum).

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, round counter 0, x0..x4 0, P 0, tag_ok 0, out_valid 0, in_ready 1 after the state settles.
REQ-027 Reset mid-operation SHALL abandon the request with no output handshake; first accept possible on the first edge after rst_n rises.

Configuration
REQ-028 With ASCON_DEC_PT_GATE_EN defined, P SHALL read 64'h0 whenever tag_ok is 0 (unverified plaintext never released).
REQ-029 Without ASCON_DEC_PT_GATE_EN, P SHALL present the recovered block regardless of tag_ok.

Verification
REQ-030 SK=N=0, A=P=0 encrypted by the team encryptor -> feed C,T: out_valid exactly 36 cycles after accept, P=0, tag_ok=1.
REQ-031 Random SK/N/A/P (1000 vectors) through encryptor then this block -> P matches original, tag_ok=1 every time.
REQ-032 Same vector with T[0] flipped -> tag_ok=0; P=0 with macro, original P without.
REQ-033 out_ready held 0 for 10 cycles in DONE -> P/tag_ok/out_valid unchanged, in_ready=0; in_valid pulses during busy ignored.
REQ-034 rst_n pulsed low during FIN round 5 -> out_valid=0, in_ready=1 at once; fresh request afterwards completes with correct P, tag_ok=1.
